// File: rtl/ps2_key_event_sequencer.sv
// Turns the PS2 receiver byte stream into {extended, break, code} key events and queues them for a consumer.
// Optional typematic-repeat filter: define PS2_REPEAT_FILTER_EN.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | 0xE0 seen
// S_BRK     | 0xF0 seen
// S_EXT_BRK | both 0xE0 and 0xF0 seen
module ps2_key_event_sequencer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clock_50,
    input  logic                          Resetn,
    input  logic [7:0]                    PS2_code,
    input  logic                          PS2_code_ready,
    input  logic                          Event_ready,
    output logic                          Event_valid,
    output logic [7:0]                    Event_code,
    output logic                          Event_extended,
    output logic                          Event_break,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
    output logic                          Overflow,
    input  logic                          Overflow_clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t     state, next_state;
    logic       ready_q;
    logic       strobe;
    logic       is_e0, is_f0, is_err;
    logic       emit, ev_ext, ev_brk;
    logic       push_req, do_push, do_pop, drop, full;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [9:0] mem [FIFO_DEPTH];
    logic [9:0] head;

    assign strobe = PS2_code_ready & ~ready_q;
    assign is_e0  = (PS2_code == 8'hE0);
    assign is_f0  = (PS2_code == 8'hF0);
    assign is_err = (PS2_code == 8'h00) || (PS2_code == 8'hFF);

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            ready_q <= 1'b0;
            state   <= S_IDLE;
        end else begin
            ready_q <= PS2_code_ready;
            state   <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (strobe) begin
            if (is_err) begin
                next_state = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_e0)      next_state = S_EXT;
                        else if (is_f0) next_state = S_BRK;
                    end
                    S_EXT: begin
                        if (is_f0)      next_state = S_EXT_BRK;
                        else if (!is_e0) next_state = S_IDLE;
                    end
                    S_BRK: begin
                        if (is_e0)      next_state = S_EXT_BRK;
                        else if (!is_f0) next_state = S_IDLE;
                    end
                    S_EXT_BRK: begin
                        if (!is_e0 && !is_f0) next_state = S_IDLE;
                    end
                    default: next_state = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        emit   = strobe & ~is_err & ~is_e0 & ~is_f0;
        ev_ext = 1'b0;
        ev_brk = 1'b0;
        case (state)
            S_EXT:     ev_ext = 1'b1;
            S_BRK:     ev_brk = 1'b1;
            S_EXT_BRK: begin
                ev_ext = 1'b1;
                ev_brk = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       last_valid, last_ext;
    logic [7:0] last_code;
    logic       last_match;

    assign last_match = last_valid && (last_ext == ev_ext) && (last_code == PS2_code);
    // Breaks always pass; makes pass only when they differ from the last held key.
    assign push_req   = emit & (ev_brk | ~last_match);

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            last_valid <= 1'b0;
            last_ext   <= 1'b0;
            last_code  <= 8'h00;
        end else if (emit) begin
            if (ev_brk) begin
                if (last_match) last_valid <= 1'b0;
            end else if (!last_match) begin
                last_valid <= 1'b1;
                last_ext   <= ev_ext;
                last_code  <= PS2_code;
            end
        end
    end
`else
    assign push_req = emit;
`endif

    assign full        = (Fifo_count == FULL_COUNT);
    assign Event_valid = (Fifo_count != '0);
    assign do_pop      = Event_valid & Event_ready;
    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign do_push     = push_req & (~full | do_pop);
    assign drop        = push_req & full & ~do_pop;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Fifo_count <= '0;
            Overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   Fifo_count <= Fifo_count + 1'b1;
                2'b01:   Fifo_count <= Fifo_count - 1'b1;
                default: ;
            endcase
            if (drop)                Overflow <= 1'b1;
            else if (Overflow_clear) Overflow <= 1'b0;
        end
    end

    always_ff @(posedge Clock_50) begin
        if (do_push) mem[wr_ptr] <= {ev_ext, ev_brk, PS2_code};
    end

    assign head           = Event_valid ? mem[rd_ptr] : 10'd0;
    assign Event_extended = head[9];
    assign Event_break    = head[8];
    assign Event_code     = head[7:0];

endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// Scoreboard bench for ps2_key_event_sequencer: stimulus queues hand-computed events,
// a negedge monitor compares every popped head entry.
module tb_ps2_key_event_sequencer;

    logic       Clock_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] PS2_code = 8'h00;
    logic       PS2_code_ready = 1'b0;
    logic       Event_ready = 1'b0;
    logic       Event_valid;
    logic [7:0] Event_code;
    logic       Event_extended;
    logic       Event_break;
    logic [3:0] Fifo_count;
    logic       Overflow;
    logic       Overflow_clear = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    ps2_key_event_sequencer #(.FIFO_DEPTH(8)) dut (
        .Clock_50(Clock_50), .Resetn(Resetn), .PS2_code(PS2_code),
        .PS2_code_ready(PS2_code_ready), .Event_ready(Event_ready),
        .Event_valid(Event_valid), .Event_code(Event_code),
        .Event_extended(Event_extended), .Event_break(Event_break),
        .Fifo_count(Fifo_count), .Overflow(Overflow), .Overflow_clear(Overflow_clear)
    );

    always #5 Clock_50 = ~Clock_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a pop happens on the next rising edge whenever valid&ready is seen here.
    always @(negedge Clock_50) begin
        if (Resetn && Event_valid && Event_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%0h required=none",
                         {Event_extended, Event_break, Event_code});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({Event_extended, Event_break, Event_code} !== e) begin
                    failures++;
                    $display("FAIL sb_event actual=%0h required=%0h",
                             {Event_extended, Event_break, Event_code}, e);
                end
            end
        end
    end

    // Returns one cycle after the strobe edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge Clock_50); #1;
        PS2_code = b;
        PS2_code_ready = 1'b1;
        @(posedge Clock_50); #1;
        PS2_code_ready = 1'b0;
    endtask

    task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic drain(input string name);
        int n;
        Event_ready = 1'b1;
        n = 0;
        while ((Fifo_count != 0 || exp_q.size() != 0) && n < 200) begin
            @(posedge Clock_50); #1;
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
        check({name, "_drain_count"}, Fifo_count, 0);
    endtask

    task automatic reset_pulse();
        @(posedge Clock_50); #1;
        Resetn = 1'b0;
        @(posedge Clock_50); #1;
        Resetn = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge Clock_50);
        #1;
        check("rst_valid", Event_valid, 0);
        check("rst_code", Event_code, 8'h00);
        check("rst_ext", Event_extended, 0);
        check("rst_brk", Event_break, 0);
        check("rst_count", Fifo_count, 0);
        check("rst_ovf", Overflow, 0);
        Resetn = 1'b1;

        // Plain make and break
        Event_ready = 1'b1;
        expect_ev(0, 0, 8'h1C);
        send_byte(8'h1C);
        check("lat_make_valid", Event_valid, 1);
        send_byte(8'hF0);
        check("brk_prefix_count", Fifo_count, 0);
        expect_ev(0, 1, 8'h1C);
        send_byte(8'h1C);
        check("lat_brk_valid", Event_valid, 1);
        drain("t1");

        // Extended make and extended break
        send_byte(8'hE0);
        check("ext_prefix_count", Fifo_count, 0);
        expect_ev(1, 0, 8'h75);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("extbrk_prefix_count", Fifo_count, 0);
        check("extbrk_prefix_valid", Event_valid, 0);
        expect_ev(1, 1, 8'h75);
        send_byte(8'h75);
        drain("t2");

        // Overflow: 9 codes into 8 entries, then clear
        Event_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_ev(0, 0, 8'h15 + 8'(i));
            send_byte(8'h15 + 8'(i));
        end
        check("ovf_count", Fifo_count, 8);
        check("ovf_set", Overflow, 1);
        @(posedge Clock_50); #1;
        PS2_code = 8'h1E;
        PS2_code_ready = 1'b1;
        Overflow_clear = 1'b1;
        @(posedge Clock_50); #1;
        PS2_code_ready = 1'b0;
        Overflow_clear = 1'b0;
        check("ovf_set_wins", Overflow, 1);
        check("ovf_drop_count", Fifo_count, 8);
        @(posedge Clock_50); #1;
        Overflow_clear = 1'b1;
        @(posedge Clock_50); #1;
        Overflow_clear = 1'b0;
        check("ovf_cleared", Overflow, 0);
        drain("t3");

        // Full FIFO: push and pop on the same edge
        Event_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_ev(0, 0, 8'h20 + 8'(i));
            send_byte(8'h20 + 8'(i));
        end
        check("full_count", Fifo_count, 8);
        expect_ev(0, 0, 8'h28);
        @(posedge Clock_50); #1;
        PS2_code = 8'h28;
        PS2_code_ready = 1'b1;
        Event_ready = 1'b1;
        @(posedge Clock_50); #1;
        PS2_code_ready = 1'b0;
        Event_ready = 1'b0;
        check("pushpop_count", Fifo_count, 8);
        check("pushpop_ovf", Overflow, 0);
        check("pushpop_head", Event_code, 8'h21);
        drain("t4");

        // Reset discards a pending prefix; error byte resets prefix
        send_byte(8'hE0);
        reset_pulse();
        expect_ev(0, 0, 8'h75);
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'hFF);
        check("err_no_event", exp_q.size(), 0);
        expect_ev(0, 0, 8'h1C);
        send_byte(8'h1C);
        drain("t5");

        // Typematic repeat
        reset_pulse();
        expect_ev(0, 0, 8'h1C);
`ifndef PS2_REPEAT_FILTER_EN
        expect_ev(0, 0, 8'h1C);
        expect_ev(0, 0, 8'h1C);
`endif
        expect_ev(0, 1, 8'h1C);
        expect_ev(0, 0, 8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_sequencer.md
# ps2_key_event_sequencer

Sequences the raw byte stream of the PS2 receiver into complete key events and buffers them for a consumer. Takes the assembled code and level-type ready flag, strips the 0xE0 (extended) and 0xF0 (break) prefix bytes with a prefix state machine, and pushes one {extended, break, code} event per key action into a FIFO. A downstream block such as the LCD/LED display logic or a character mapper pops events through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- Clock_50  input  1  system clock; all logic on rising edge
- Resetn  input  1  asynchronous, active-low reset
- PS2_code  input  8  last assembled scan-code byte from the PS2 receiver
- PS2_code_ready  input  1  level flag from the receiver; rises once per new byte, falls at next start bit
- Event_ready  input  1  consumer accepts head event
- Event_valid  output  1  FIFO non-empty
- Event_code  output  8  head event scan code (prefixes removed)
- Event_extended  output  1  head event preceded by 0xE0
- Event_break  output  1  head event preceded by 0xF0 (key release)
- Fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
- Overflow  output  1  sticky: an event was dropped because the FIFO was full
- Overflow_clear  input  1  synchronous clear of Overflow

## Operation
- Byte strobe: ready_q registers PS2_code_ready; a byte is processed on the edge where PS2_code_ready=1 and ready_q=0. PS2_code is sampled on that edge. At most one byte per rising edge of the flag.
- Prefix FSM, states S_IDLE, S_EXT, S_BRK, S_EXT_BRK:
  - S_IDLE: 0xE0→S_EXT; 0xF0→S_BRK; other→emit {0,0,code}, stay.
  - S_EXT: 0xF0→S_EXT_BRK; 0xE0→stay; other→emit {1,0,code}, →S_IDLE.
  - S_BRK: 0xE0→S_EXT_BRK; 0xF0→stay; other→emit {0,1,code}, →S_IDLE.
  - S_EXT_BRK: 0xE0/0xF0→stay; other→emit {1,1,code}, →S_IDLE.
  - 0x00 and 0xFF (keyboard error/overrun) in any state: no event, →S_IDLE.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. Push on emit; pop when Event_valid & Event_ready.
- Push and pop on the same edge: both happen, count unchanged, including when full (no overflow) and when count=1.
- Push when full without pop: event dropped, FIFO unchanged, Overflow←1.
- Overflow_clear: Overflow←0, unless a drop occurs on the same edge, in which case set wins.
- Event_code/Event_extended/Event_break show the head entry when Event_valid=1; they are forced to 0 when empty.
- Event_ready while empty: ignored.

## Timing
- Reset: FSM S_IDLE, ready_q 0, pointers 0, Fifo_count 0, Event_valid 0, Event_code 0x00, Event_extended 0, Event_break 0, Overflow 0, FIFO contents don't-care.
- Latency: a code byte strobed at edge k into an empty FIFO gives Event_valid=1 and the head fields after edge k, one cycle.
- A pop at edge k presents the next entry, or valid=0, after edge k.
- Fifo_count and Overflow are registered and update on the same edge as the push, pop, or drop.
- Reset mid-sequence, for example after 0xE0: the prefix is discarded and the next byte decodes from S_IDLE.

## Configuration
- PS2_REPEAT_FILTER_EN defined: a last-make register {valid, ext, code} is added.
  - A make event equal to the stored {ext, code} is discarded, which filters typematic repeat.
  - Any other make event is pushed and overwrites the register.
  - A break event is always pushed; if its {ext, code} matches, it clears valid.
  - The register resets to valid=0.
- Undefined: every make event is pushed, including repeats.

## Test plan
- Bytes 0x1C; 0xF0, 0x1C with Event_ready=1 → events {0,0,0x1C} then {0,1,0x1C}. Event_valid rises one cycle after each code strobe.
- Bytes 0xE0, 0x75; 0xE0, 0xF0, 0x75 → {1,0,0x75}, {1,1,0x75}. Prefix bytes alone produce no event and Fifo_count stays 0.
- FIFO_DEPTH=8, Event_ready=0, 9 codes 0x15..0x1D → Fifo_count=8, Overflow=1, and popping yields 0x15..0x1C in order. Pulse Overflow_clear → Overflow=0.
- FIFO full with Event_ready=1 held while a new code is strobed on the same edge as a pop → Fifo_count stays 8, Overflow stays 0, and the pointers wrap correctly.
- Byte 0xE0, then Resetn pulse, then 0x75 → {0,0,0x75}. Byte 0xFF in S_BRK, then 0x1C → {0,0,0x1C}.
- With PS2_REPEAT_FILTER_EN: 0x1C ×3, 0xF0 0x1C, 0x1C → events {0,0,1C}, {0,1,1C}, {0,0,1C}. Without the macro: 5 events.
